// File: rtl/encoder4x2_seq.sv
// ---------------------------------------------------------------------------
// encoder4x2_seq
//
// Registered 4-to-2 priority encoder with a 2-entry output FIFO.
//
// Each accepted request word d (qualified by en) is encoded into an entry
// {code, any, err}. The entry is pushed into a small two-deep FIFO and is
// presented downstream through a valid/ready handshake. A saturating counter
// tracks how many accepted words were multi-hot.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      upstream word valid
//   in_ready   out  1      block can accept a word this cycle (registered)
//   d          in   4      request word, d[i] requests code i
//   en         in   1      encode enable, sampled together with d
//   out_valid  out  1      FIFO head holds a valid entry
//   out_ready  in   1      downstream accepts the head entry
//   code       out  2      index of the highest set request bit
//   any        out  1      at least one request bit was set with en=1
//   err        out  1      more than one request bit was set with en=1
//   err_cnt    out  CNT_W  saturating count of accepted multi-hot words
// ---------------------------------------------------------------------------
module encoder4x2_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       d,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       code,
  output logic             any,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  // The state encoding doubles as the occupancy count (0, 1 or 2 entries).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fifo_state_t state;
  fifo_state_t state_next;

  logic       push;
  logic       pop;

  logic [1:0] enc_code;
  logic       enc_any;
  logic       enc_err;
  logic [2:0] ones;
  logic [3:0] enc_entry;

  // Entry layout: [3:2] code, [1] any, [0] err.
  logic [3:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [3:0] head;

  // Handshakes. in_ready is a register, so the accept condition never
  // depends combinationally on out_ready.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Priority encode of the incoming word. With en low everything reads zero;
  // with en high and d zero the fall-through also yields code 0.
  always_comb begin
    enc_code = 2'd0;
    enc_any  = 1'b0;
    enc_err  = 1'b0;
    ones     = {2'b00, d[0]} + {2'b00, d[1]} + {2'b00, d[2]} + {2'b00, d[3]};
    if (en) begin
      if (d[3]) begin
        enc_code = 2'd3;
      end else if (d[2]) begin
        enc_code = 2'd2;
      end else if (d[1]) begin
        enc_code = 2'd1;
      end else begin
        enc_code = 2'd0;
      end
      enc_any = (d != 4'b0000);
      enc_err = (ones >= 3'd2);
    end
  end

  assign enc_entry = {enc_code, enc_any, enc_err};

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Occupancy transitions. A push in FULL cannot happen because in_ready is
  // already low there, so FULL only reacts to a pop.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_next = FULL;
        end else if (pop && !push) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // in_ready is registered from the next occupancy. It is held low during
  // reset and rises on the first edge after reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= (state_next != FULL);
    end
  end

  // Storage and pointers. One-bit pointers wrap naturally modulo 2, which
  // keeps acceptance order across the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem[i] <= 4'b0000;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Multi-hot counter, counted at acceptance and held at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (push && enc_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  // Outputs come from the FIFO head and are forced to zero when empty, so
  // nothing stale is visible after reset or after the last pop.
  assign head      = mem[rd_ptr];
  assign out_valid = (state != EMPTY);
  assign code      = out_valid ? head[3:2] : 2'd0;
  assign any       = out_valid ? head[1]   : 1'b0;
  assign err       = out_valid ? head[0]   : 1'b0;

endmodule

// File: tb/tb_encoder4x2_seq.sv
// ---------------------------------------------------------------------------
// tb_encoder4x2_seq
//
// Directed bench for encoder4x2_seq (CNT_W=2 so counter saturation is
// reachable). Expected entries are computed from the stimulus and queued at
// acceptance; the queue head is compared whenever the DUT presents output.
// ---------------------------------------------------------------------------
module tb_encoder4x2_seq;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       d;
  logic             en;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       code;
  logic             any;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  logic [3:0] sb_q[$];
  int         model_cnt;
  logic       exp_ready;
  int         asserts;
  int         fails;

  encoder4x2_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .any       (any),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding: scan upward so the highest set bit wins.
  function automatic logic [3:0] modelEntry(input logic [3:0] dd, input logic e);
    logic [1:0] c;
    logic       a;
    logic       m;
    c = 2'd0;
    a = 1'b0;
    m = 1'b0;
    if (e) begin
      for (int i = 0; i < 4; i++) begin
        if (dd[i]) c = 2'(i);
      end
      a = (dd != 4'b0000);
      m = ($countones(dd) >= 2);
    end
    return {c, a, m};
  endfunction

  // One immediate-assertion comparison point.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check outputs against the model, then
  // advance one edge and update the scoreboard with what was accepted/popped.
  task automatic applyStimulus(input logic v, input logic [3:0] dd, input logic e,
                               input logic rdy, input string tag);
    logic       do_pop;
    logic       do_push;
    logic [3:0] entry;
    in_valid  = v;
    d         = dd;
    en        = e;
    out_ready = rdy;
    #1;
    checkOutput({tag, ".out_valid"}, 8'(out_valid), 8'(sb_q.size() != 0));
    checkOutput({tag, ".in_ready"},  8'(in_ready),  8'(exp_ready));
    checkOutput({tag, ".err_cnt"},   8'(err_cnt),   8'(model_cnt));
    if (sb_q.size() != 0) begin
      checkOutput({tag, ".entry"}, 8'({code, any, err}), 8'(sb_q[0]));
    end else begin
      checkOutput({tag, ".idle"}, 8'({code, any, err}), 8'h00);
    end
    do_pop  = (sb_q.size() != 0) && rdy;
    do_push = v && exp_ready;
    @(posedge clk);
    #1;
    if (do_pop) begin
      entry = sb_q.pop_front();
    end
    if (do_push) begin
      entry = modelEntry(dd, e);
      sb_q.push_back(entry);
      if (entry[0] && (model_cnt < CNT_MAX)) model_cnt++;
    end
    exp_ready = (sb_q.size() != 2);
  endtask

  // Assert reset between edges, check the immediate effect, release it and
  // check that in_ready rises on the first edge afterwards.
  task automatic applyReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, ".out_valid"}, 8'(out_valid), 8'h00);
    checkOutput({tag, ".err_cnt"},   8'(err_cnt),   8'h00);
    checkOutput({tag, ".in_ready"},  8'(in_ready),  8'h00);
    checkOutput({tag, ".entry"},     8'({code, any, err}), 8'h00);
    sb_q.delete();
    model_cnt = 0;
    exp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_ready = 1'b1;
    checkOutput({tag, ".ready_after"}, 8'(in_ready), 8'h01);
  endtask

  initial begin
    asserts   = 0;
    fails     = 0;
    model_cnt = 0;
    exp_ready = 1'b0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    d         = 4'b0000;
    en        = 1'b0;
    out_ready = 1'b0;
    #1;
    applyReset("reset");

    $display("[TB] one-hot sweep");
    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b1, "onehot0");
    applyStimulus(1'b1, 4'b0010, 1'b1, 1'b1, "onehot1");
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b1, "onehot2");
    applyStimulus(1'b1, 4'b1000, 1'b1, 1'b1, "onehot3");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "onehot_drain");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "onehot_idle");

    $display("[TB] enable and zero");
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, "en_off");
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1, "zero");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "zero_drain");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "zero_idle");

    $display("[TB] multi-hot");
    applyStimulus(1'b1, 4'b1010, 1'b1, 1'b1, "multi_a");
    applyStimulus(1'b1, 4'b0110, 1'b1, 1'b1, "multi_b");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "multi_drain");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "multi_idle");

    $display("[TB] backpressure");
    applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0, "bp_push1");
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0, "bp_push2");
    applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0, "bp_reject");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, "bp_hold");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "bp_pop1");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "bp_pop2");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "bp_idle");

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 4'b0011, 1'b1, 1'b0, "mid_fill1");
    applyStimulus(1'b1, 4'b1100, 1'b1, 1'b0, "mid_fill2");
    applyReset("midreset");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "mid_after1");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "mid_after2");

    $display("[TB] saturation with simultaneous push/pop");
    applyStimulus(1'b1, 4'b0011, 1'b1, 1'b0, "sat_w1");
    applyStimulus(1'b1, 4'b0101, 1'b1, 1'b1, "sat_w2");
    applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1, "sat_w3");
    applyStimulus(1'b1, 4'b1110, 1'b1, 1'b1, "sat_w4");
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1, "sat_w5");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "sat_drain");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "sat_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
